vote_press_driver: RTL and testbench
====================================

Name: vote_press_driver

Overview:
- Synthesizable initiator for the voting machine's raw button interface. It turns queued vote requests into clean or bouncy long-press waveforms on button1_raw..button4_raw.
- It satisfies the voting machine's debounce and long-press timing by construction.
- It sits between a test or automation controller and votingMachine, for on-chip self-test and hardware-in-loop vote injection.

Parameters:
- DEBOUNCE_CYCLES, 500: receiver debounce length in clocks.
- LONG_PRESS_CYCLES, 11: receiver long-press qualification in clocks.
- HOLD_MARGIN, 50: extra steady-high clocks beyond debounce plus long-press.
- RELEASE_MARGIN, 50: extra low clocks beyond debounce after release.
- BOUNCE_TOGGLES, 0: number of output toggles injected at press start. Must be even; 0 disables bounce.
- BOUNCE_PERIOD, 3: clocks between bounce toggles; must be at least 1.
- FIFO_DEPTH, 4: request queue depth; must be a power of 2, at least 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  vote request valid.
- req_cand  in  2  candidate index; 0..3 maps to button1..button4.
- req_ready  out  1  queue can accept a request.
- abort  in  1  synchronous flush; cancels the queue and any press in progress.
- button1_raw  out  1  drive to votingMachine.
- button2_raw  out  1  drive to votingMachine.
- button3_raw  out  1  drive to votingMachine.
- button4_raw  out  1  drive to votingMachine.
- busy  out  1  FSM not in IDLE, or queue non-empty.
- done_pulse  out  1  one-cycle pulse per completed press.
- issued_total  out  16  count of completed presses, saturating.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.

Behaviour:
- Derived constants:
  - HOLD_TOTAL = DEBOUNCE_CYCLES + LONG_PRESS_CYCLES + HOLD_MARGIN (default 561).
  - RELEASE_TOTAL = DEBOUNCE_CYCLES + RELEASE_MARGIN (default 550).
- Reset (reset=0, asynchronous):
  - All buttons 0, state IDLE, queue emptied, fifo_level 0.
  - issued_total 0, done_pulse 0, busy 0.
  - req_ready 1 from the first clock edge after deassertion.
  - A mid-press reset drops the buttons immediately; no done_pulse is issued for the interrupted press.
- Queue:
  - Push on the clock edge where req_valid=1 and req_ready=1. req_ready = (fifo_level < FIFO_DEPTH), a registered-level function.
  - When full, req_ready=0 and requests are ignored.
  - A push and pop on the same edge leave the level unchanged.
  - Ordering is FIFO; pointers wrap modulo FIFO_DEPTH.
- FSM states and transitions:
  - IDLE: if the queue is non-empty, pop on this edge and latch cand. Drive the selected button to 1 on the same edge. Go to BOUNCE if BOUNCE_TOGGLES>0, else HOLD.
  - BOUNCE: the selected button toggles every BOUNCE_PERIOD clocks, BOUNCE_TOGGLES times in total. The state is entered high, so the line ends high. Then go to HOLD.
  - HOLD: the selected button stays steady 1 for exactly HOLD_TOTAL clocks, then all buttons go to 0 and the FSM moves to RELEASE.
  - RELEASE: all buttons stay 0 for exactly RELEASE_TOTAL clocks. On the final edge go to IDLE with done_pulse=1 for one cycle, and issued_total increments, saturating at 16'hFFFF.
- Latency and spacing:
  - A request accepted at edge k into an empty queue with the FSM idle is popped at edge k+1; the button is high from edge k+1.
  - Back-to-back queued requests produce a low gap of RELEASE_TOTAL+1 clocks between presses.
- At most one button is ever 1. Buttons are registered outputs with no combinational path from inputs.
- Abort (synchronous, has priority over push and pop on the same edge):
  - Queue is emptied and all buttons go 0.
  - If the FSM was in BOUNCE or HOLD, it goes to RELEASE with the counter reloaded. The cancelled press gives no done_pulse and no increment.
  - If the FSM was in RELEASE, it continues unchanged.
  - If the FSM was in IDLE, it stays in IDLE.
- busy = (state != IDLE) or (fifo_level != 0).

Test Plan:
- Single vote: push cand=1 at edge k → button2_raw high from edge k+1 for exactly 561 clocks, low for 550 → done_pulse at IDLE entry, issued_total=1; other buttons stay 0 throughout.
- Queue fill: push 5 requests back-to-back with FIFO_DEPTH=4 (first pop is at the edge after the first push) → the 5th is accepted only after that pop. Presses appear in push order with 551-clock low gaps; issued_total=5.
- Integration: drive votingMachine with 3×cand0, 6×cand1, 4×cand2, 1×cand3 → counts 3/6/4/1, winner_id=2, winner_votes=6, tie=0.
- Bounce: BOUNCE_TOGGLES=4, BOUNCE_PERIOD=3 → 4 toggles 3 clocks apart, then 561 steady-high clocks; votingMachine registers exactly 1 vote.
- Abort mid-HOLD at clock 200 with 2 queued → buttons 0 next cycle, fifo_level=0, no done_pulse, issued_total unchanged; RELEASE completes, busy=0.
- Reset asserted mid-HOLD → buttons 0 without a clock edge; after release req_ready=1, issued_total=0.

Source files
------------

// File: rtl/vote_press_driver.sv
// Queued vote-press generator for the voting machine's raw button inputs.
// Each request becomes a (optionally bouncy) long press followed by a release gap.
//
// state   | meaning
// IDLE    | waiting for a queued request; pops and raises the button on the same edge
// BOUNCE  | selected button toggles every BOUNCE_PERIOD clocks, ends high
// HOLD    | selected button steady high for HOLD_TOTAL clocks
// RELEASE | all buttons low for RELEASE_TOTAL clocks, then done_pulse
module vote_press_driver #(
  parameter int DEBOUNCE_CYCLES   = 500,
  parameter int LONG_PRESS_CYCLES = 11,
  parameter int HOLD_MARGIN       = 50,
  parameter int RELEASE_MARGIN    = 50,
  parameter int BOUNCE_TOGGLES    = 0,
  parameter int BOUNCE_PERIOD     = 3,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic [1:0]                    req_cand,
  output logic                          req_ready,
  input  logic                          abort,
  output logic                          button1_raw,
  output logic                          button2_raw,
  output logic                          button3_raw,
  output logic                          button4_raw,
  output logic                          busy,
  output logic                          done_pulse,
  output logic [15:0]                   issued_total,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int HOLD_TOTAL    = DEBOUNCE_CYCLES + LONG_PRESS_CYCLES + HOLD_MARGIN;
  localparam int RELEASE_TOTAL = DEBOUNCE_CYCLES + RELEASE_MARGIN;
  localparam int MAX_T0        = (HOLD_TOTAL > RELEASE_TOTAL) ? HOLD_TOTAL : RELEASE_TOTAL;
  localparam int MAX_T         = (MAX_T0 > BOUNCE_PERIOD) ? MAX_T0 : BOUNCE_PERIOD;
  localparam int CNT_W         = $clog2(MAX_T + 1);
  localparam int TOG_W         = $clog2(BOUNCE_TOGGLES + 2);
  localparam int PTR_W         = $clog2(FIFO_DEPTH);
  localparam int LVL_W         = PTR_W + 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_TOTAL - 1);
  localparam logic [CNT_W-1:0] REL_LOAD    = CNT_W'(RELEASE_TOTAL - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_PERIOD - 1);
  localparam logic [TOG_W-1:0] TOG_LOAD    = TOG_W'(BOUNCE_TOGGLES);

  typedef enum logic [1:0] {IDLE, BOUNCE, HOLD, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TOG_W-1:0]   tog_q, tog_d;
  logic [1:0]         cand_q, cand_d;
  logic [3:0]         btn_q, btn_d;
  logic               cancel_q, cancel_d;
  logic               done_q, done_d;
  logic [15:0]        issued_q, issued_d;
  logic               ready_en_q, ready_en_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [1:0]         mem_q [FIFO_DEPTH];
  logic [1:0]         mem_d [FIFO_DEPTH];
  logic               push, pop;
  logic [1:0]         head_cand;

  assign req_ready = ready_en_q && (level_q < LVL_W'(FIFO_DEPTH));
  assign head_cand = mem_q[rd_ptr_q];
  assign push      = req_valid && req_ready && !abort;
  assign pop       = (state_q == IDLE) && (level_q != '0) && !abort;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tog_d      = tog_q;
    cand_d     = cand_q;
    btn_d      = btn_q;
    cancel_d   = cancel_q;
    done_d     = 1'b0;
    issued_d   = issued_q;
    ready_en_d = 1'b1;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    mem_d      = mem_q;

    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = req_cand;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (pop) begin
          cand_d   = head_cand;
          btn_d    = 4'b0001 << head_cand;
          cancel_d = 1'b0;
          if (BOUNCE_TOGGLES > 0) begin
            state_d = BOUNCE;
            cnt_d   = BOUNCE_LOAD;
            tog_d   = TOG_LOAD;
          end else begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
      end
      BOUNCE: begin
        if (abort) begin
          state_d  = RELEASE;
          btn_d    = '0;
          cnt_d    = REL_LOAD;
          cancel_d = 1'b1;
        end else if (cnt_q == '0) begin
          btn_d = btn_q ^ (4'b0001 << cand_q);
          if (tog_q == TOG_W'(1)) begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            cnt_d = BOUNCE_LOAD;
            tog_d = tog_q - TOG_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (abort) begin
          state_d  = RELEASE;
          btn_d    = '0;
          cnt_d    = REL_LOAD;
          cancel_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = RELEASE;
          btn_d   = '0;
          cnt_d   = REL_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          // an aborted press still serves its release gap but is not counted
          if (!cancel_q) begin
            done_d   = 1'b1;
            issued_d = (issued_q == 16'hFFFF) ? issued_q : issued_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tog_q      <= '0;
      cand_q     <= '0;
      btn_q      <= '0;
      cancel_q   <= 1'b0;
      done_q     <= 1'b0;
      issued_q   <= '0;
      ready_en_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tog_q      <= tog_d;
      cand_q     <= cand_d;
      btn_q      <= btn_d;
      cancel_q   <= cancel_d;
      done_q     <= done_d;
      issued_q   <= issued_d;
      ready_en_q <= ready_en_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      mem_q      <= mem_d;
    end
  end

  assign button1_raw  = btn_q[0];
  assign button2_raw  = btn_q[1];
  assign button3_raw  = btn_q[2];
  assign button4_raw  = btn_q[3];
  assign done_pulse   = done_q;
  assign issued_total = issued_q;
  assign fifo_level   = level_q;
  assign busy         = (state_q != IDLE) || (level_q != '0);

endmodule

// File: tb/tb_vote_press_driver.sv
// Scoreboard bench for vote_press_driver: a timeline model predicts each press's
// waveform and completion edge; a negedge monitor compares outputs and done pulses.
module tb_vote_press_driver;
  localparam int DEB = 500, LP = 11, HM = 50, RM = 50, BT = 4, BP = 3, FD = 4;
  localparam int HOLD_T = DEB + LP + HM;
  localparam int REL_T  = DEB + RM;

  logic        clock = 1'b0, reset = 1'b0, req_valid = 1'b0, abort = 1'b0;
  logic [1:0]  req_cand = 2'd0;
  logic        req_ready, busy, done_pulse;
  logic        button1_raw, button2_raw, button3_raw, button4_raw;
  logic [15:0] issued_total;
  logic [2:0]  fifo_level;

  vote_press_driver #(
    .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LP), .HOLD_MARGIN(HM),
    .RELEASE_MARGIN(RM), .BOUNCE_TOGGLES(BT), .BOUNCE_PERIOD(BP), .FIFO_DEPTH(FD)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_cand(req_cand),
    .req_ready(req_ready), .abort(abort),
    .button1_raw(button1_raw), .button2_raw(button2_raw),
    .button3_raw(button3_raw), .button4_raw(button4_raw),
    .busy(busy), .done_pulse(done_pulse), .issued_total(issued_total),
    .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  typedef struct { int cand; int done_edge; } exp_t;
  exp_t exp_q[$];
  int   fifo_m[$];

  int   ecnt = 0;
  int   pop_edge = -1, drop_edge = -1, idle_edge = -1, act_cand = 0;
  bit   m_ready = 1'b0, last_acc = 1'b0, m_busy = 1'b0;
  logic [3:0] m_btn = 4'd0;
  int   n_checks = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, ecnt);
    end
  endtask

  // Reference timeline: each press is a pop edge plus fixed offsets.
  always @(posedge clock) begin
    int k;
    bit can_push;
    ecnt++;
    last_acc = 1'b0;
    if (!reset) begin
      fifo_m.delete();
      exp_q.delete();
      pop_edge = -1; drop_edge = -1; idle_edge = -1;
      m_ready = 1'b0;
    end else begin
      can_push = m_ready && req_valid;
      if (abort) begin
        fifo_m.delete();
        if (ecnt > pop_edge && ecnt <= drop_edge) begin
          drop_edge = ecnt;
          idle_edge = ecnt + REL_T;
          if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
      end else begin
        if (ecnt > idle_edge && fifo_m.size() > 0) begin
          act_cand  = fifo_m.pop_front();
          pop_edge  = ecnt;
          drop_edge = ecnt + BT * BP + HOLD_T;
          idle_edge = drop_edge + REL_T;
          exp_q.push_back('{act_cand, idle_edge});
        end
        if (can_push) begin
          fifo_m.push_back(int'(req_cand));
          last_acc = 1'b1;
        end
      end
      m_ready = fifo_m.size() < FD;
    end
    m_btn = 4'd0;
    if (reset && pop_edge >= 0 && ecnt >= pop_edge && ecnt < drop_edge) begin
      k = ecnt - pop_edge;
      m_btn[act_cand] = (k < BT * BP) ? (((k / BP) % 2) == 0) : 1'b1;
    end
    m_busy = reset && (ecnt < idle_edge || fifo_m.size() != 0);
  end

  int mon_issued = 0;
  int last_hi = -1;
  always @(negedge clock) begin
    exp_t e;
    logic [3:0] btns;
    btns = {button4_raw, button3_raw, button2_raw, button1_raw};
    if (!reset) begin
      check("reset_buttons", int'(btns), 0);
      check("reset_ready", int'(req_ready), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_issued", int'(issued_total), 0);
      check("reset_level", int'(fifo_level), 0);
      mon_issued = 0;
      last_hi = -1;
    end else begin
      check("buttons", int'(btns), int'(m_btn));
      check("req_ready", int'(req_ready), int'(m_ready));
      check("busy", int'(busy), int'(m_busy));
      check("fifo_level", int'(fifo_level), fifo_m.size());
      for (int i = 0; i < 4; i++) if (btns[i]) last_hi = i;
      if (done_pulse) begin
        check("done_has_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("done_edge", ecnt, e.done_edge);
          check("done_cand", last_hi, e.cand);
          if (mon_issued < 16'hFFFF) mon_issued++;
        end
      end else if (exp_q.size() > 0 && ecnt >= exp_q[0].done_edge) begin
        check("done_pulse", int'(done_pulse), 1);
        void'(exp_q.pop_front());
      end
      check("issued_total", int'(issued_total), mon_issued);
    end
  end

  task automatic send(input int c);
    int t;
    req_valid = 1'b1;
    req_cand  = 2'(c);
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!last_acc && t < 5000);
    check("accept", int'(last_acc), 1);
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while ((m_busy || exp_q.size() > 0) && t < budget) begin
      @(negedge clock);
      t++;
    end
    repeat (2) @(negedge clock);
    check("idle_reached", int'(busy), 0);
  endtask

  initial begin
    int saved;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("ready_after_reset", int'(req_ready), 1);

    send(1);
    req_valid = 1'b0;
    wait_idle(3000);
    check("issued_single", int'(issued_total), 1);

    for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 3)));
    req_valid = 1'b0;
    wait_idle(8000);
    check("issued_fill", int'(issued_total), 6);

    for (int i = 0; i < 10; i++) begin
      send(int'($urandom_range(0, 3)));
      req_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    wait_idle(15000);
    check("issued_random", int'(issued_total), 16);

    saved = int'(issued_total);
    send(2); send(3); send(0);
    req_valid = 1'b0;
    repeat (200) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_hold_level", int'(fifo_level), 0);
    check("abort_hold_btn", int'({button4_raw, button3_raw, button2_raw, button1_raw}), 0);
    wait_idle(2000);
    check("abort_hold_issued", int'(issued_total), saved);

    send(1);
    req_valid = 1'b0;
    repeat (5) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    wait_idle(2000);
    check("abort_bounce_issued", int'(issued_total), saved);

    send(3);
    req_valid = 1'b0;
    repeat (800) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    wait_idle(2000);
    check("abort_release_issued", int'(issued_total), saved + 1);

    abort = 1'b1; req_valid = 1'b1; req_cand = 2'd2;
    @(negedge clock);
    abort = 1'b0; req_valid = 1'b0;
    check("abort_push_level", int'(fifo_level), 0);
    wait_idle(100);

    send(0); send(1);
    req_valid = 1'b0;
    repeat (300) @(negedge clock);
    @(posedge clock);
    #1 check("pre_reset_btn", int'(button1_raw), 1);
    #1 reset = 1'b0;
    #1 check("async_reset_btn", int'({button4_raw, button3_raw, button2_raw, button1_raw}), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("ready_after_reset2", int'(req_ready), 1);
    check("issued_after_reset", int'(issued_total), 0);

    send(2);
    req_valid = 1'b0;
    wait_idle(3000);
    check("issued_final", int'(issued_total), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
